// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - next-PC, branch resolution and misalign trap for the RV32I core
//
// Ports:
//   clk, rst         core clock; synchronous active-high reset
//   stall            hold pc/counter this cycle (RUN only)
//   branch/jal/jalr  decoded control-transfer kind (jalr > jal > branch)
//   funct3           branch condition select
//   a_eq_b/a_lt_b/a_ltu_b  comparator flags
//   imm, rs1_data    sign-extended immediate, JALR base
//   trap_ack         handler acknowledge pulse, leaves TRAP
//   pc, pc_plus4     registered PC and its link value
//   taken            combinational transfer-taken flag
//   misalign_trap    high while in TRAP
//   trap_addr        registered faulting target
//   taken_cnt        committed taken redirects
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch,
  input  logic             jal,
  input  logic             jalr,
  input  logic [2:0]       funct3,
  input  logic             a_eq_b,
  input  logic             a_lt_b,
  input  logic             a_ltu_b,
  input  logic [31:0]      imm,
  input  logic [31:0]      rs1_data,
  input  logic             trap_ack,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             taken,
  output logic             misalign_trap,
  output logic [31:0]      trap_addr,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic {RUN, TRAP} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      trap_addr_q, trap_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        cond;
  logic        xfer_req;
  logic [31:0] target;
  logic        misaligned;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = a_eq_b;
      3'b001:  cond = ~a_eq_b;
      3'b100:  cond = a_lt_b;
      3'b101:  cond = ~a_lt_b;
      3'b110:  cond = a_ltu_b;
      3'b111:  cond = ~a_ltu_b;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    target   = pc_q + imm;
    xfer_req = 1'b0;
    if (jalr) begin
      // LSB cleared before the alignment check, so only bit 1 can fault.
      target   = (rs1_data + imm) & ~32'h1;
      xfer_req = 1'b1;
    end else if (jal) begin
      xfer_req = 1'b1;
    end else if (branch) begin
      xfer_req = cond;
    end
  end

  assign taken      = (state_q == RUN) && xfer_req;
  assign misaligned = taken && (target[1:0] != 2'b00);
  assign pc_plus4   = pc_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    trap_addr_d = trap_addr_q;
    cnt_d       = cnt_q;
    case (state_q)
      RUN: begin
        if (!stall) begin
          if (misaligned) begin
            // pc stays on the faulting instruction.
            trap_addr_d = target;
            state_d     = TRAP;
          end else if (taken) begin
            pc_d  = target;
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      TRAP: begin
        if (trap_ack) begin
          pc_d    = TRAP_VEC;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      trap_addr_q <= 32'h0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      trap_addr_q <= trap_addr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pc            = pc_q;
  assign misalign_trap = (state_q == TRAP);
  assign trap_addr     = trap_addr_q;
  assign taken_cnt     = cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb/tb_branch_pc_unit.sv - directed vector bench for branch_pc_unit
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branch, jal, jalr;
  logic [2:0]  funct3;
  logic        a_eq_b, a_lt_b, a_ltu_b;
  logic [31:0] imm, rs1_data;
  logic        trap_ack;
  logic [31:0] pc, pc_plus4, trap_addr;
  logic        taken, misalign_trap;
  logic [15:0] taken_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] cnt_model = 16'h0;

  always #5 clk = ~clk;

  branch_pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .jal(jal), .jalr(jalr),
    .funct3(funct3), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b), .a_ltu_b(a_ltu_b),
    .imm(imm), .rs1_data(rs1_data), .trap_ack(trap_ack),
    .pc(pc), .pc_plus4(pc_plus4), .taken(taken), .misalign_trap(misalign_trap),
    .trap_addr(trap_addr), .taken_cnt(taken_cnt)
  );

  typedef struct {
    logic [31:0] start_pc;
    logic        br, j, jr;
    logic [2:0]  f3;
    logic        eq, lt, ltu;
    logic [31:0] im, rs1;
    logic        exp_taken;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    stall = 1'b0; branch = 1'b0; jal = 1'b0; jalr = 1'b0; funct3 = 3'b000;
    a_eq_b = 1'b0; a_lt_b = 1'b0; a_ltu_b = 1'b0; imm = 32'h0; rs1_data = 32'h0;
    trap_ack = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Redirect pc with an aligned JALR; counts as a taken redirect.
  task automatic set_pc(input logic [31:0] t);
    clear_inputs();
    jalr = 1'b1; rs1_data = t;
    tick();
    clear_inputs();
    cnt_model = cnt_model + 16'd1;
    chk("set_pc", pc, t);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();

    vecs[0]  = '{32'h10, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 1'b1, 32'h30};
    vecs[1]  = '{32'h10, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h14};
    vecs[2]  = '{32'h40, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0, 1'b0, 32'h44};
    vecs[3]  = '{32'h40, 1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0, 1'b1, 32'h38};
    vecs[4]  = '{32'h40, 1'b1, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0, 1'b1, 32'h38};
    vecs[5]  = '{32'h40, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0, 1'b0, 32'h44};
    vecs[6]  = '{32'h40, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 1'b1, 32'h8, 32'h0, 1'b0, 32'h44};
    vecs[7]  = '{32'h100, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h4, 32'h2001, 1'b1, 32'h2004};
    vecs[8]  = '{32'h100, 1'b1, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h4, 32'h2001, 1'b1, 32'h2004};
    vecs[9]  = '{32'h200, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'h240};
    vecs[10] = '{32'h40, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h2, 32'h0, 1'b0, 32'h44};
    vecs[11] = '{32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0};

    // Reset
    tick();
    chk("reset_pc", pc, 32'h0);
    chk("reset_cnt", {16'h0, taken_cnt}, 32'h0);
    chk("reset_trap", {31'h0, misalign_trap}, 32'h0);
    chk("reset_trap_addr", trap_addr, 32'h0);
    rst = 1'b0;
    tick();
    chk("first_seq_pc", pc, 32'h4);

    // Vector table
    foreach (vecs[i]) begin
      set_pc(vecs[i].start_pc);
      branch = vecs[i].br; jal = vecs[i].j; jalr = vecs[i].jr; funct3 = vecs[i].f3;
      a_eq_b = vecs[i].eq; a_lt_b = vecs[i].lt; a_ltu_b = vecs[i].ltu;
      imm = vecs[i].im; rs1_data = vecs[i].rs1;
      #1;
      chk($sformatf("v%0d_taken", i), {31'h0, taken}, {31'h0, vecs[i].exp_taken});
      chk($sformatf("v%0d_pc_plus4", i), pc_plus4, vecs[i].start_pc + 32'd4);
      @(posedge clk);
      #1;
      clear_inputs();
      if (vecs[i].exp_taken) cnt_model = cnt_model + 16'd1;
      chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("v%0d_cnt", i), {16'h0, taken_cnt}, {16'h0, cnt_model});
      chk($sformatf("v%0d_trap", i), {31'h0, misalign_trap}, 32'h0);
    end

    // Stall holds pc and counter, and suppresses misalign evaluation
    set_pc(32'h10);
    stall = 1'b1; branch = 1'b1; funct3 = 3'b000; a_eq_b = 1'b1; imm = 32'h20;
    tick();
    chk("stall_pc", pc, 32'h10);
    chk("stall_cnt", {16'h0, taken_cnt}, {16'h0, cnt_model});
    imm = 32'h6;
    tick();
    chk("stall_misalign_pc", pc, 32'h10);
    chk("stall_misalign_trap", {31'h0, misalign_trap}, 32'h0);
    clear_inputs();

    // Misalign trap
    set_pc(32'h80);
    jal = 1'b1; imm = 32'h6;
    #1;
    chk("trap_taken_comb", {31'h0, taken}, 32'h1);
    @(posedge clk);
    #1;
    chk("trap_pc", pc, 32'h80);
    chk("trap_flag", {31'h0, misalign_trap}, 32'h1);
    chk("trap_addr", trap_addr, 32'h86);
    chk("trap_cnt", {16'h0, taken_cnt}, {16'h0, cnt_model});
    for (int k = 0; k < 3; k++) begin
      stall = k[0]; jal = ~k[0]; imm = 32'h10;
      #1;
      chk("trap_taken_forced", {31'h0, taken}, 32'h0);
      @(posedge clk);
      #1;
      chk("trap_hold_pc", pc, 32'h80);
      chk("trap_hold_flag", {31'h0, misalign_trap}, 32'h1);
      chk("trap_hold_addr", trap_addr, 32'h86);
    end
    clear_inputs();
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    chk("ack_pc", pc, 32'h100);
    chk("ack_flag", {31'h0, misalign_trap}, 32'h0);
    chk("ack_addr_kept", trap_addr, 32'h86);
    chk("ack_cnt", {16'h0, taken_cnt}, {16'h0, cnt_model});
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    chk("ack_in_run_pc", pc, 32'h104);
    chk("ack_in_run_flag", {31'h0, misalign_trap}, 32'h0);

    // JALR bit 1 misaligned, then reset out of TRAP
    jalr = 1'b1; rs1_data = 32'h2003; imm = 32'h0;
    tick();
    clear_inputs();
    chk("jalr_trap_flag", {31'h0, misalign_trap}, 32'h1);
    chk("jalr_trap_addr", trap_addr, 32'h2002);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt_model = 16'h0;
    chk("rst_in_trap_pc", pc, 32'h0);
    chk("rst_in_trap_flag", {31'h0, misalign_trap}, 32'h0);
    chk("rst_in_trap_addr", trap_addr, 32'h0);
    tick();
    chk("rst_in_trap_run", pc, 32'h4);

    // Counter wrap: JAL with imm 0 redirects to itself, aligned
    jal = 1'b1; imm = 32'h0;
    repeat (65535) @(posedge clk);
    #1;
    chk("cnt_full", {16'h0, taken_cnt}, 32'h0000_FFFF);
    chk("cnt_full_pc", pc, 32'h4);
    tick();
    chk("cnt_wrap", {16'h0, taken_cnt}, 32'h0);
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
Next-PC and branch-resolution stage sitting directly downstream of the 32-bit comparator in the single-cycle RV32I core. Consumes the comparator's equal/less-than flags together with the decoded branch/jump controls. Resolves taken/not-taken, computes the target and owns the architectural PC register. Detects misaligned control-transfer targets and holds the core in a trap state until acknowledged.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TRAP_VEC, 32'h0000_0100, PC loaded when a misalign trap is acknowledged
CNT_W, 16, width of the taken-redirect counter

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
stall  in  1  hold PC and counter this cycle (RUN state only)
branch  in  1  current instruction is a conditional branch
jal  in  1  current instruction is JAL
jalr  in  1  current instruction is JALR
funct3  in  3  branch condition select
a_eq_b  in  1  comparator: rs1 == rs2
a_lt_b  in  1  comparator: rs1 < rs2, signed
a_ltu_b  in  1  comparator: rs1 < rs2, unsigned
imm  in  32  sign-extended B/J/I immediate
rs1_data  in  32  rs1 value for JALR
trap_ack  in  1  trap handler acknowledge, one-cycle pulse
pc  out  32  current PC (registered)
pc_plus4  out  32  pc + 4, for JAL/JALR link write
taken  out  1  control transfer taken this cycle (combinational)
misalign_trap  out  1  high while in TRAP state
trap_addr  out  32  offending target address (registered)
taken_cnt  out  CNT_W  count of committed taken redirects

Behaviour:
- Reset (rst=1 at clk edge, highest priority, any state): pc=RESET_PC, state=RUN, misalign_trap=0, trap_addr=0, taken_cnt=0.
- Condition decode (branch path): 000 BEQ a_eq_b; 001 BNE !a_eq_b; 100 BLT a_lt_b; 101 BGE !a_lt_b; 110 BLTU a_ltu_b; 111 BGEU !a_ltu_b; 010/011 reserved -> not taken.
- Control priority when several asserted: jalr > jal > branch. jal/jalr are always taken.
- Target: branch/jal = pc + imm; jalr = (rs1_data + imm) & ~32'h1. All adds modulo 2^32, wrap silently.
- pc_plus4 = pc + 4, modulo 2^32 (32'hFFFF_FFFC -> 0).
- taken = RUN & resolved condition. Forced 0 in TRAP.
- Misaligned: taken & target[1:0] != 2'b00, evaluated after the JALR LSB clear. Not-taken branches never trap.
- States: RUN, TRAP.
- RUN, stall=1: pc, taken_cnt and state hold. Misalign is not evaluated.
- RUN, stall=0, taken, aligned: pc <= target; taken_cnt++ (wraps at 2^CNT_W-1 -> 0).
- RUN, stall=0, taken, misaligned: pc holds (faulting instruction); trap_addr <= target; state -> TRAP. Counter does not increment.
- RUN, stall=0, not taken: pc <= pc + 4.
- TRAP: misalign_trap=1 (registered, asserted the cycle after detection). pc, trap_addr and counter hold. stall and all control inputs are ignored.
- TRAP, trap_ack=1: pc <= TRAP_VEC; state -> RUN; misalign_trap=0 next cycle. trap_addr retains its value.
- trap_ack in RUN is ignored.
- Latency: pc updates one cycle after the resolving inputs. taken and pc_plus4 are same-cycle combinational.

Test Plan:
- Reset: rst=1 one edge -> pc=0, taken_cnt=0, misalign_trap=0; next edge, no control inputs -> pc=4.
- BEQ taken: pc=0x10, branch=1, funct3=000, a_eq_b=1, imm=0x20 -> taken=1; next pc=0x30, taken_cnt=1. Same stimulus with funct3=001 -> pc=0x14.
- Signed vs unsigned: a_lt_b=0, a_ltu_b=1, imm=-8, pc=0x40. funct3=100 -> pc=0x44. funct3=110 -> pc=0x38.
- JALR LSB clear: pc=0x100, jalr=1, rs1_data=0x2001, imm=0x4 -> pc=0x2004, pc_plus4 was 0x104. Same with jal=1 and branch=1 also asserted -> JALR target still wins.
- Misalign trap: pc=0x80, jal=1, imm=0x6 -> pc stays 0x80; misalign_trap=1; trap_addr=0x86. stall and jal toggling for 3 cycles -> no change. trap_ack -> pc=0x100, misalign_trap=0. rst asserted mid-TRAP -> pc=0, RUN.
- Stall and wrap: stall=1 with a taken BEQ -> pc and counter unchanged. Preload taken_cnt to 0xFFFF via taken jumps, one more taken -> 0x0000. pc=0xFFFF_FFFC not taken -> pc=0.
